ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifq_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-side constants and the queue entry layout for ifetch_queue.
package ifetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifq_fifo.sv
// Circular FIFO with synchronous clear; count disambiguates full from empty.
module ifq_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited memory issue, in-order response
// capture into a small queue, and redirect handling with stale-response drops.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RedirectE,
  input  logic [31:0] PCTargetE,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IRValid,
  input  logic [31:0] IRData,
  output logic        ValidF,
  input  logic        ReadyD,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_pc4;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;
  logic [CW:0]   inflight;
  logic          resp_any;
  logic          drop_resp;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign target    = PCTargetE & ~32'h3;
  assign inflight  = {1'b0, occupancy} + {1'b0, outstanding};
  assign resp_any  = IRValid && (outstanding != '0);
  assign drop_resp = resp_any && (drop_cnt != '0);
  assign push      = resp_any && (drop_cnt == '0) && !RedirectE;
  assign pop       = ValidF && ReadyD && !RedirectE;

  // Credit rule: queued plus in-flight never exceeds the queue, so no overflow.
  assign IReq  = reset && !RedirectE && !fifo_full
              && (outstanding < CW'(MAX_OUT))
              && (inflight < (CW+1)'(DEPTH));
  assign IAddr = fetch_pc;

  assign push_entry.instr = IRData;
  assign push_entry.pc    = resp_pc;
  assign push_entry.pc4   = resp_pc + 32'd4;

  ifq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (RedirectE),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign ValidF   = !fifo_empty;
  assign InstrF   = fifo_empty ? NOP_INSTR : head.instr;
  assign PCF      = fifo_empty ? hold_pc   : head.pc;
  assign PCPlus4F = fifo_empty ? hold_pc4  : head.pc4;

  // resp_pc names the address of the next response that will be kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      hold_pc     <= '0;
      hold_pc4    <= '0;
    end else begin
      case ({IReq, resp_any})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (RedirectE) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding - CW'(resp_any);
      end else begin
        if (IReq)      fetch_pc <= fetch_pc + 32'd4;
        if (push)      resp_pc  <= resp_pc + 32'd4;
        if (drop_resp) drop_cnt <= drop_cnt - 1'b1;
      end
      if (!fifo_empty) begin
        hold_pc  <= head.pc;
        hold_pc4 <= head.pc4;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: memory model with in-order variable latency,
// epoch-tagged reference model of the decode-visible instruction stream.
module tb_ifetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        RedirectE;
  logic [31:0] PCTargetE;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IRValid;
  logic [31:0] IRData;
  logic        ValidF;
  logic        ReadyD;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RST_PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RedirectE (RedirectE),
    .PCTargetE (PCTargetE),
    .IReq      (IReq),
    .IAddr     (IAddr),
    .IRValid   (IRValid),
    .IRData    (IRData),
    .ValidF    (ValidF),
    .ReadyD    (ReadyD),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t        pend[$];
  exp_t        expq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          armed = 0;
  bit          resp_real = 0;
  bit          force_spur = 0;
  int          spur_pct = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_pc4 = 32'h0;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; memory answers in order.
  task automatic step(input bit rst_n, input bit redir, input logic [31:0] tgt, input bit rdy);
    @(posedge clk);
    #1;
    reset     = rst_n;
    RedirectE = redir;
    PCTargetE = tgt;
    ReadyD    = rdy;
    IRValid   = 1'b0;
    IRData    = $urandom;
    resp_real = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      IRValid   = 1'b1;
      IRData    = memfun(pend[0].addr);
      resp_real = 1'b1;
    end else if (pend.size() == 0 && (force_spur || $urandom_range(0, 99) < spur_pct)) begin
      IRValid = 1'b1;
      IRData  = 32'hDEAD_BEEF;
    end
    force_spur = 1'b0;
  endtask

  // Monitor and reference model, evaluated at the falling edge.
  always @(negedge clk) begin
    bit   exp_ireq;
    req_t r;
    exp_t e;
    int   lat;
    exp_ireq = reset && !RedirectE && (pend.size() < MAX_OUT)
               && (expq.size() + pend.size() < DEPTH);
    if (armed) begin
      chk("ireq", 32'(IReq), 32'(exp_ireq));
      chk("iaddr", IAddr, m_pc);
      chk("validf", 32'(ValidF), 32'(expq.size() > 0));
      if (expq.size() > 0) begin
        chk("pcf", PCF, expq[0].pc);
        chk("pcplus4f", PCPlus4F, expq[0].pc + 32'd4);
        chk("instrf", InstrF, expq[0].instr);
      end else begin
        chk("instrf_nop", InstrF, NOP);
        chk("pcf_hold", PCF, last_pc);
        chk("pcplus4f_hold", PCPlus4F, last_pc4);
      end
    end
    if (!reset) begin
      pend.delete();
      expq.delete();
      m_pc     = RST_PC;
      last_pc  = 32'h0;
      last_pc4 = 32'h0;
      epoch++;
      last_due = cyc;
      armed    = 1'b1;
    end else begin
      if (expq.size() > 0) begin
        last_pc  = expq[0].pc;
        last_pc4 = expq[0].pc + 32'd4;
      end
      if (!RedirectE && ReadyD && expq.size() > 0) begin
        void'(expq.pop_front());
        pops++;
      end
      if (IRValid && resp_real && pend.size() > 0) begin
        r = pend.pop_front();
        if (!RedirectE && r.epoch == epoch) begin
          e.pc    = r.addr;
          e.instr = memfun(r.addr);
          expq.push_back(e);
        end
      end
      if (RedirectE) begin
        expq.delete();
        m_pc = PCTargetE & ~32'h3;
        epoch++;
      end else if (exp_ireq) begin
        lat      = $urandom_range(lat_min, lat_max);
        r.addr   = m_pc;
        r.epoch  = epoch;
        r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  end

  initial begin
    reset     = 1'b0;
    RedirectE = 1'b0;
    PCTargetE = 32'h0;
    IRValid   = 1'b0;
    IRData    = 32'h0;
    ReadyD    = 1'b0;

    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Streaming from reset with single-cycle memory.
    repeat (20) step(1'b1, 1'b0, 32'h0, 1'b1);
    // Decode stall fills the queue, then drains.
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    // Redirect to a misaligned target with slow memory and requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    repeat (15) step(1'b1, 1'b0, 32'h0, 1'b1);
    // Redirect while the queue holds entries and pushes/pops are pending.
    lat_min = 1; lat_max = 1;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    // Address wrap at the top of the space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1);
    // Reset with requests in flight, then a late strobe at release.
    lat_min = 2; lat_max = 2;
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    force_spur = 1'b1;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    // Random traffic.
    lat_min = 1; lat_max = 4; spur_pct = 10;
    for (int i = 0; i < 1600; i++) begin
      int  roll;
      bit  rdy;
      roll = $urandom_range(0, 999);
      rdy  = ($urandom_range(0, 3) != 0);
      if (roll < 8) begin
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 32'h0, rdy);
      end else if (roll < 60) begin
        step(1'b1, 1'b1, $urandom, rdy);
      end else begin
        step(1'b1, 1'b0, $urandom, rdy);
      end
    end
    @(negedge clk);
    #1;
    chk("progress", 32'(pops >= 200), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
